// File: rtl/obi_mem_pkg.sv
// Shared types and default sizes for the multi-port OBI memory responder.
package obi_mem_pkg;

    localparam int OBI_ADDR_W    = 32;
    localparam int OBI_DATA_W    = 32;
    localparam int OBI_MEM_WORDS = 4096;
    localparam int BE_W          = OBI_DATA_W / 8;
    localparam int OBI_OFF_W     = $clog2(BE_W);
    localparam int OBI_IDX_W     = $clog2(OBI_MEM_WORDS);

    typedef struct packed {
        logic                  valid;
        logic                  err;
        logic [OBI_DATA_W-1:0] rdata;
    } obi_rsp_t;

    function automatic logic [OBI_IDX_W-1:0] word_idx(input logic [OBI_ADDR_W-1:0] addr);
        return addr[OBI_OFF_W +: OBI_IDX_W];
    endfunction

endpackage

// File: rtl/obi_mem_port.sv
// One request channel: grant gating, outstanding-request counter and the
// fixed-latency response pipe carrying {valid, err, rdata}.
module obi_mem_port
    import obi_mem_pkg::*;
#(
    parameter int DATA_W          = OBI_DATA_W,
    parameter int RSP_LAT         = 1,
    parameter int MAX_OUTSTANDING = 2
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              i_req,
    input  logic              i_stall,
    input  logic              i_we,
    input  logic              i_err,
    input  logic [DATA_W-1:0] i_rdata,
    output logic              o_gnt,
    output logic              o_accept,
    output logic              o_rvalid,
    output logic              o_err,
    output logic [DATA_W-1:0] o_rdata
);

    localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);

    logic [CNT_W-1:0] r_cnt;
    obi_rsp_t         r_pipe [RSP_LAT];
    obi_rsp_t         w_rsp_in;
    obi_rsp_t         w_rsp_out;
    logic [CNT_W-1:0] w_cnt_live;

    assign w_rsp_out = r_pipe[RSP_LAT-1];

    // A response leaving this cycle frees its slot, so MAX_OUTSTANDING >= RSP_LAT
    // sustains one accept per cycle.
    assign w_cnt_live = r_cnt - CNT_W'(w_rsp_out.valid);
    assign o_gnt      = rst_ni & ~i_stall & (w_cnt_live < CNT_W'(MAX_OUTSTANDING));
    assign o_accept   = i_req & o_gnt;

    always_comb begin
        w_rsp_in = '0;
        if (o_accept) begin
            w_rsp_in.valid = 1'b1;
            w_rsp_in.err   = i_err;
            w_rsp_in.rdata = (i_err || i_we) ? '0 : i_rdata;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_cnt <= '0;
            for (int i = 0; i < RSP_LAT; i++) begin
                r_pipe[i] <= '0;
            end
        end else begin
            r_cnt     <= r_cnt + CNT_W'(o_accept) - CNT_W'(w_rsp_out.valid);
            r_pipe[0] <= w_rsp_in;
            for (int i = 1; i < RSP_LAT; i++) begin
                r_pipe[i] <= r_pipe[i-1];
            end
        end
    end

    assign o_rvalid = w_rsp_out.valid;
    assign o_err    = w_rsp_out.err;
    assign o_rdata  = w_rsp_out.rdata;

endmodule

// File: rtl/obi_mem_responder.sv
// Multi-port OBI memory slave: shared word array, per-port latency pipes and a backdoor loader.
// Defining OBI_MEM_ERR_INJECT_EN adds err_inject_i, which turns an accepted request into an error response.
module obi_mem_responder
    import obi_mem_pkg::*;
#(
    parameter int N_PORTS         = 2,
    parameter int ADDR_W          = OBI_ADDR_W,
    parameter int DATA_W          = OBI_DATA_W,
    parameter int MEM_WORDS       = OBI_MEM_WORDS,
    parameter int RSP_LAT         = 1,
    parameter int MAX_OUTSTANDING = 2
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  logic [N_PORTS-1:0]            req_i,
    output logic [N_PORTS-1:0]            gnt_o,
    input  logic [N_PORTS*ADDR_W-1:0]     addr_i,
    input  logic [N_PORTS-1:0]            we_i,
    input  logic [N_PORTS*(DATA_W/8)-1:0] be_i,
    input  logic [N_PORTS*DATA_W-1:0]     wdata_i,
    output logic [N_PORTS-1:0]            rvalid_o,
    output logic [N_PORTS*DATA_W-1:0]     rdata_o,
    output logic [N_PORTS-1:0]            err_o,
    input  logic [N_PORTS-1:0]            stall_i,
`ifdef OBI_MEM_ERR_INJECT_EN
    input  logic [N_PORTS-1:0]            err_inject_i,
`endif
    input  logic                          ld_en_i,
    input  logic [$clog2(MEM_WORDS)-1:0]  ld_addr_i,
    input  logic [DATA_W-1:0]             ld_wdata_i
);

    localparam int BYTES = DATA_W / 8;
    localparam int OFF_W = $clog2(BYTES);
    localparam int IDX_W = $clog2(MEM_WORDS);

    logic [DATA_W-1:0]               r_mem [MEM_WORDS];
    logic [N_PORTS-1:0]              w_accept;
    logic [N_PORTS-1:0]              w_inj;
    logic [N_PORTS-1:0]              w_addr_err;
    logic [N_PORTS-1:0][IDX_W-1:0]   w_idx;
    logic [N_PORTS-1:0][DATA_W-1:0]  w_rdata;

`ifdef OBI_MEM_ERR_INJECT_EN
    assign w_inj = err_inject_i;
`else
    assign w_inj = '0;
`endif

    for (genvar p = 0; p < N_PORTS; p++) begin : g_port
        logic [ADDR_W-1:0] w_addr;

        assign w_addr   = addr_i[p*ADDR_W +: ADDR_W];
        assign w_idx[p] = w_addr[OFF_W +: IDX_W];
        // The index compare only matters for non-power-of-two depths.
        assign w_addr_err[p] = ((w_addr >> (OFF_W + IDX_W)) != '0) ||
                               (32'(w_idx[p]) >= MEM_WORDS);
        // Sampled before the edge, so a same-cycle write returns the old word.
        assign w_rdata[p] = r_mem[w_idx[p]];

        obi_mem_port #(
            .DATA_W          (DATA_W),
            .RSP_LAT         (RSP_LAT),
            .MAX_OUTSTANDING (MAX_OUTSTANDING)
        ) u_port (
            .clk_i    (clk_i),
            .rst_ni   (rst_ni),
            .i_req    (req_i[p]),
            .i_stall  (stall_i[p]),
            .i_we     (we_i[p]),
            .i_err    (w_addr_err[p] | w_inj[p]),
            .i_rdata  (w_rdata[p]),
            .o_gnt    (gnt_o[p]),
            .o_accept (w_accept[p]),
            .o_rvalid (rvalid_o[p]),
            .o_err    (err_o[p]),
            .o_rdata  (rdata_o[p*DATA_W +: DATA_W])
        );
    end

    // Later assignments win: higher port index per byte, backdoor over everything.
    always_ff @(posedge clk_i) begin
        for (int p = 0; p < N_PORTS; p++) begin
            if (w_accept[p] && we_i[p] && !w_addr_err[p] && !w_inj[p]) begin
                for (int b = 0; b < BYTES; b++) begin
                    if (be_i[p*BYTES + b]) begin
                        r_mem[w_idx[p]][b*8 +: 8] <= wdata_i[p*DATA_W + b*8 +: 8];
                    end
                end
            end
        end
        if (ld_en_i) begin
            r_mem[ld_addr_i] <= ld_wdata_i;
        end
    end

endmodule

// File: tb/tb_obi_mem_responder.sv
// Bench for obi_mem_responder: directed scenarios plus randomized traffic against a queue-based model.
`timescale 1ns/1ps
module tb_obi_mem_responder;

    localparam int NP   = 2;
    localparam int AW   = 32;
    localparam int DW   = 32;
    localparam int BW   = 4;
    localparam int MW   = 4096;
    localparam int LAT  = 3;
    localparam int MAXO = 2;

    logic            clk_i = 1'b0;
    logic            rst_ni;
    logic [NP-1:0]   req_i, gnt_o, we_i, rvalid_o, err_o, stall_i;
    logic [NP*AW-1:0] addr_i;
    logic [NP*BW-1:0] be_i;
    logic [NP*DW-1:0] wdata_i, rdata_o;
    logic            ld_en_i;
    logic [11:0]     ld_addr_i;
    logic [31:0]     ld_wdata_i;
`ifdef OBI_MEM_ERR_INJECT_EN
    logic [NP-1:0]   err_inject_i;
`endif

    obi_mem_responder #(
        .N_PORTS(NP), .ADDR_W(AW), .DATA_W(DW), .MEM_WORDS(MW),
        .RSP_LAT(LAT), .MAX_OUTSTANDING(MAXO)
    ) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .req_i(req_i), .gnt_o(gnt_o),
        .addr_i(addr_i), .we_i(we_i), .be_i(be_i), .wdata_i(wdata_i),
        .rvalid_o(rvalid_o), .rdata_o(rdata_o), .err_o(err_o), .stall_i(stall_i),
`ifdef OBI_MEM_ERR_INJECT_EN
        .err_inject_i(err_inject_i),
`endif
        .ld_en_i(ld_en_i), .ld_addr_i(ld_addr_i), .ld_wdata_i(ld_wdata_i)
    );

    always #5 clk_i = ~clk_i;

    // stimulus state, applied to the pins at each falling edge
    logic          t_rst;
    logic [NP-1:0] t_req, t_we, t_stall, t_inj;
    logic [31:0]   t_addr [NP];
    logic [31:0]   t_wdata [NP];
    logic [3:0]    t_be [NP];
    logic          t_ld_en;
    logic [11:0]   t_ld_addr;
    logic [31:0]   t_ld_wdata;
    logic          t_auto_drop;

    typedef struct {
        int          due;
        logic        err;
        logic [31:0] data;
    } rsp_t;

    logic [31:0] mdl_mem [MW];
    rsp_t        exp_q [NP][$];
    int          cyc;
    int          n_checks;
    int          n_err;
    logic [31:0] last_rdata [NP];
    logic        last_err [NP];
    int          last_acc_cyc [NP];
    int          last_rv_cyc [NP];
    int          rv_seen [NP];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s cycle=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
        end
    endtask

    // One clock: drive pins, check outputs against the model, advance the model.
    task automatic cycle();
        logic [NP-1:0] acc;
        logic          e [NP];
        int            idx [NP];
        @(negedge clk_i);
        rst_ni     = t_rst;
        req_i      = t_req;
        we_i       = t_we;
        stall_i    = t_stall;
        ld_en_i    = t_ld_en;
        ld_addr_i  = t_ld_addr;
        ld_wdata_i = t_ld_wdata;
`ifdef OBI_MEM_ERR_INJECT_EN
        err_inject_i = t_inj;
`endif
        for (int p = 0; p < NP; p++) begin
            addr_i[p*AW +: AW]  = t_addr[p];
            be_i[p*BW +: BW]    = t_be[p];
            wdata_i[p*DW +: DW] = t_wdata[p];
        end
        #1;
        acc = '0;
        for (int p = 0; p < NP; p++) begin
            logic exp_rv;
            logic exp_g;
            if (!t_rst) exp_q[p].delete();
            exp_rv = (exp_q[p].size() > 0) && (exp_q[p][0].due == cyc);
            chk($sformatf("rvalid%0d", p), rvalid_o[p], exp_rv);
            if (rvalid_o[p]) begin
                last_rdata[p]  = rdata_o[p*DW +: DW];
                last_err[p]    = err_o[p];
                last_rv_cyc[p] = cyc;
                rv_seen[p]++;
            end
            if (exp_rv) begin
                rsp_t r;
                r = exp_q[p].pop_front();
                chk($sformatf("rdata%0d", p), rdata_o[p*DW +: DW], r.data);
                chk($sformatf("err%0d", p), err_o[p], r.err);
            end
            exp_g = t_rst && !t_stall[p] && (exp_q[p].size() < MAXO);
            chk($sformatf("gnt%0d", p), gnt_o[p], exp_g);
            acc[p] = t_req[p] && exp_g;
        end
        // all reads see memory as it was before this cycle's writes
        for (int p = 0; p < NP; p++) begin
            e[p]   = t_inj[p] || (t_addr[p] >= 32'(MW * BW));
            idx[p] = e[p] ? 0 : int'(t_addr[p] / BW);
            if (acc[p]) begin
                rsp_t r;
                r.due  = cyc + LAT;
                r.err  = e[p];
                r.data = (e[p] || t_we[p]) ? 32'h0 : mdl_mem[idx[p]];
                exp_q[p].push_back(r);
                last_acc_cyc[p] = cyc;
            end
        end
        for (int p = 0; p < NP; p++) begin
            if (acc[p] && t_we[p] && !e[p])
                for (int b = 0; b < BW; b++)
                    if (t_be[p][b]) mdl_mem[idx[p]][8*b +: 8] = t_wdata[p][8*b +: 8];
            if (acc[p] && t_auto_drop) t_req[p] = 1'b0;
        end
        if (t_ld_en) mdl_mem[t_ld_addr] = t_ld_wdata;
        cyc++;
    endtask

    task automatic ld(input logic [11:0] a, input logic [31:0] d);
        t_ld_en = 1'b1; t_ld_addr = a; t_ld_wdata = d;
        cycle();
        t_ld_en = 1'b0;
    endtask

    task automatic set_txn(input int p, input logic we, input logic [31:0] addr,
                           input logic [3:0] be, input logic [31:0] wd);
        t_we[p] = we; t_addr[p] = addr; t_be[p] = be; t_wdata[p] = wd; t_req[p] = 1'b1;
    endtask

    task automatic wait_acc();
        for (int i = 0; i < 50 && (t_req != '0); i++) cycle();
        chk("acc_timeout", t_req, '0);
    endtask

    task automatic issue(input int p, input logic we, input logic [31:0] addr,
                         input logic [3:0] be, input logic [31:0] wd);
        set_txn(p, we, addr, be, wd);
        wait_acc();
    endtask

    task automatic drain();
        int pend;
        pend = exp_q[0].size() + exp_q[1].size();
        for (int i = 0; i < 50 && pend != 0; i++) begin
            cycle();
            pend = exp_q[0].size() + exp_q[1].size();
        end
        chk("drain_timeout", pend, 0);
    endtask

    initial begin
        logic [5:0] pat;
        int rv_before;
        n_checks = 0; n_err = 0; cyc = 0;
        t_rst = 1'b0; t_req = '0; t_we = '0; t_stall = '0; t_inj = '0;
        t_ld_en = 1'b0; t_ld_addr = '0; t_ld_wdata = '0; t_auto_drop = 1'b1;
        for (int p = 0; p < NP; p++) begin
            t_addr[p] = '0; t_wdata[p] = '0; t_be[p] = '0;
            last_rdata[p] = '0; last_err[p] = 1'b0;
            last_acc_cyc[p] = 0; last_rv_cyc[p] = 0; rv_seen[p] = 0;
        end
        for (int i = 0; i < MW; i++) mdl_mem[i] = '0;

        cycle();
        chk("rst_gnt", gnt_o, '0);
        chk("rst_rvalid", rvalid_o, '0);
        chk("rst_rdata", rdata_o, '0);
        chk("rst_err", err_o, '0);

        // backdoor preload while still in reset
        for (int i = 0; i < 64; i++) ld(12'(i), $urandom);
        for (int i = MW - 4; i < MW; i++) ld(12'(i), $urandom);
        ld(12'h010, 32'hDEADBEEF);
        ld(12'h020, 32'hFFFFFFFF);
        ld(12'h030, 32'h0);
        t_rst = 1'b1;
        cycle();

        // T1: read backdoor word, latency
        issue(0, 1'b0, 32'h40, 4'hF, 32'h0);
        drain();
        chk("t1_rdata", last_rdata[0], 32'hDEADBEEF);
        chk("t1_err", last_err[0], 1'b0);
        chk("t1_latency", last_rv_cyc[0] - last_acc_cyc[0], LAT);

        // T2: partial byte write
        issue(1, 1'b1, 32'h80, 4'b0101, 32'h11223344);
        drain();
        chk("t2_wr_rdata", last_rdata[1], 32'h0);
        issue(1, 1'b0, 32'h82, 4'hF, 32'h0);
        drain();
        chk("t2_rdata", last_rdata[1], 32'hFF22FF44);

        // T3: throughput throttle with req held
        pat = 6'b011011;
        t_auto_drop = 1'b0;
        set_txn(0, 1'b0, 32'h44, 4'hF, 32'h0);
        for (int i = 0; i < 6; i++) begin
            cycle();
            chk("t3_gnt_pattern", gnt_o[0], pat[i]);
        end
        t_req[0] = 1'b0;
        t_auto_drop = 1'b1;
        drain();

        // T4: same-word write conflict and read-before-write
        set_txn(0, 1'b1, 32'hC0, 4'hF, 32'hAAAAAAAA);
        set_txn(1, 1'b1, 32'hC0, 4'hF, 32'h55555555);
        wait_acc();
        drain();
        issue(0, 1'b0, 32'hC0, 4'hF, 32'h0);
        drain();
        chk("t4_conflict", last_rdata[0], 32'h55555555);
        set_txn(0, 1'b0, 32'hC0, 4'hF, 32'h0);
        set_txn(1, 1'b1, 32'hC0, 4'hF, 32'h12345678);
        wait_acc();
        drain();
        chk("t4_read_old", last_rdata[0], 32'h55555555);
        issue(0, 1'b0, 32'hC0, 4'hF, 32'h0);
        drain();
        chk("t4_read_new", last_rdata[0], 32'h12345678);
        t_ld_en = 1'b1; t_ld_addr = 12'h030; t_ld_wdata = 32'hCAFEF00D;
        issue(1, 1'b1, 32'hC0, 4'hF, 32'h01010101);
        t_ld_en = 1'b0;
        drain();
        issue(1, 1'b0, 32'hC0, 4'hF, 32'h0);
        drain();
        chk("t4_backdoor_wins", last_rdata[1], 32'hCAFEF00D);

        // T5: address errors
        issue(0, 1'b0, 32'h4000, 4'hF, 32'h0);
        drain();
        chk("t5_err", last_err[0], 1'b1);
        chk("t5_rdata", last_rdata[0], 32'h0);
        issue(1, 1'b1, 32'h80000040, 4'hF, 32'h0BADF00D);
        drain();
        chk("t5_wr_err", last_err[1], 1'b1);
`ifdef OBI_MEM_ERR_INJECT_EN
        t_inj[1] = 1'b1;
        issue(1, 1'b1, 32'h40, 4'hF, 32'h0BADF00D);
        t_inj[1] = 1'b0;
        drain();
        chk("t5_inj_err", last_err[1], 1'b1);
`endif
        issue(0, 1'b0, 32'h40, 4'hF, 32'h0);
        drain();
        chk("t5_mem_unchanged", last_rdata[0], 32'hDEADBEEF);
        issue(0, 1'b0, 32'h3FFF, 4'hF, 32'h0);
        drain();
        chk("t5_top_word_err", last_err[0], 1'b0);

        // T6: reset with two reads in flight
        t_auto_drop = 1'b0;
        set_txn(0, 1'b0, 32'h40, 4'hF, 32'h0);
        cycle();
        cycle();
        t_req[0] = 1'b0;
        t_auto_drop = 1'b1;
        rv_before = rv_seen[0];
        t_rst = 1'b0;
        cycle();
        t_rst = 1'b1;
        cycle();
        chk("t6_gnt", gnt_o[0], 1'b1);
        for (int i = 0; i < 6; i++) cycle();
        chk("t6_no_rvalid", rv_seen[0] - rv_before, 0);

        // randomized traffic
        for (int n = 0; n < 800; n++) begin
            for (int p = 0; p < NP; p++) begin
                if (!t_req[p] && $urandom_range(0, 2) != 0) begin
                    logic [31:0] a;
                    case ($urandom_range(0, 15))
                        0:       a = 32'h4000 + $urandom_range(0, 255);
                        1:       a = 32'h80000000 | ($urandom_range(0, 15) * 4);
                        2:       a = 32'h3FFC | $urandom_range(0, 3);
                        default: a = ($urandom_range(0, 15) * 4) | $urandom_range(0, 3);
                    endcase
                    set_txn(p, 1'($urandom_range(0, 1)), a, 4'($urandom), $urandom);
`ifdef OBI_MEM_ERR_INJECT_EN
                    t_inj[p] = ($urandom_range(0, 7) == 0);
`endif
                end
                t_stall[p] = ($urandom_range(0, 3) == 0);
            end
            t_ld_en    = ($urandom_range(0, 7) == 0);
            t_ld_addr  = 12'($urandom_range(0, 15));
            t_ld_wdata = $urandom;
            cycle();
        end
        t_ld_en = 1'b0;
        t_stall = '0;
        wait_acc();
        drain();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
        $finish;
    end

endmodule
